// File: rtl/tag_pkg.sv
// Shared tag definitions for the dispatch/retire tag loop.
package tag_pkg;

  localparam int unsigned TAG_W_DEF = 5;
  localparam int unsigned DEPTH_DEF = 32;

  typedef logic [TAG_W_DEF-1:0] tag_t;

endpackage

// File: rtl/tag_store_ram.sv
// Free-tag storage: one write port, one asynchronous read port, identity preload.
module tag_store_ram #(
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DEPTH  = 32,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              i_init,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [TAG_W-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [TAG_W-1:0]  o_rdata
);

  logic [TAG_W-1:0] r_mem [DEPTH];

  // Preload entry i with tag i, otherwise accept one write per cycle.
  always_ff @(posedge clock) begin
    if (i_init) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= TAG_W'(i);
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/free_tag_pool.sv
// Free-tag pool: circular list of unallocated tags plus an in-use tracker
// that rejects returns of tags that are out of range or already free.
module free_tag_pool
  import tag_pkg::*;
#(
  parameter int unsigned TAG_W     = TAG_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter bit          INIT_FULL = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       Flush,
  input  logic [TAG_W-1:0]           RB_Tag,
  input  logic                       RB_Tag_Valid,
  input  logic                       Rd_en,
  output logic [TAG_W-1:0]           Tag_Out,
  output logic                       Tag_Out_Valid,
  output logic                       tagFifo_full,
  output logic                       tagFifo_empty,
  output logic [$clog2(DEPTH):0]     tagFifo_count,
  output logic                       Ret_Err,
  output logic                       Udf_Err
);

  localparam int unsigned      PTR_W     = $clog2(DEPTH);
  localparam int unsigned      CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [TAG_W:0]   TAG_LIMIT = (TAG_W + 1)'(DEPTH);

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] r_in_use;
  logic             r_ret_err;
  logic             r_udf_err;

  logic             w_init;
  logic [TAG_W-1:0] w_head;
  logic             w_pop_ok;
  logic             w_push_ok;
  logic             w_in_range;
  logic [DEPTH-1:0] w_pop_mask;
  logic [DEPTH-1:0] w_ret_mask;
  logic [DEPTH-1:0] w_in_use_pop;
  logic [CNT_W-1:0] w_count_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_init = !reset || Flush;

  tag_store_ram #(
    .TAG_W (TAG_W),
    .DEPTH (DEPTH)
  ) u_store (
    .clock   (clock),
    .i_init  (w_init && INIT_FULL),
    .i_we    (w_push_ok && !w_init),
    .i_waddr (r_wr_ptr),
    .i_wdata (RB_Tag),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  // Request decode: the pop marks its tag in use before the return is checked.
  always_comb begin
    w_pop_mask  = '0;
    w_ret_mask  = '0;
    w_count_nxt = r_count;
    w_pop_ok    = Rd_en && (r_count != '0);
    if (w_pop_ok) begin
      w_pop_mask[PTR_W'(w_head)] = 1'b1;
    end
    w_in_use_pop = r_in_use | w_pop_mask;
    w_in_range   = ({1'b0, RB_Tag} < TAG_LIMIT);
    w_push_ok    = RB_Tag_Valid && w_in_range && w_in_use_pop[PTR_W'(RB_Tag)];
    if (w_push_ok) begin
      w_ret_mask[PTR_W'(RB_Tag)] = 1'b1;
    end
    if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop_ok && !w_push_ok) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Pointer, count, tracker and error-pulse state; reset and flush share one image.
  always_ff @(posedge clock) begin
    if (w_init) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= INIT_FULL ? CNT_FULL : '0;
      r_in_use  <= {DEPTH{~INIT_FULL}};
      r_ret_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else begin
      if (w_pop_ok) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_push_ok) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      r_count   <= w_count_nxt;
      r_in_use  <= w_in_use_pop & ~w_ret_mask;
      r_ret_err <= RB_Tag_Valid && !w_push_ok;
      r_udf_err <= Rd_en && (r_count == '0);
    end
  end

  assign Tag_Out       = w_head;
  assign Tag_Out_Valid = (r_count != '0);
  assign tagFifo_full  = (r_count == CNT_FULL);
  assign tagFifo_empty = (r_count == '0);
  assign tagFifo_count = r_count;
  assign Ret_Err       = r_ret_err;
  assign Udf_Err       = r_udf_err;

endmodule
